f1_start_ctrl: RTL and testbench
================================

// Module: f1_start_ctrl
// PURPOSE
// - Race-start controller that sequences the 8-light F1 start gantry: trigger -> lights fill one per tick
//   -> random hold -> lights out -> reaction-time measurement.
// - Owns tick generation, LFSR random delay, jump-start detection and cmd_seq/cmd_delay status; sits
//   between board buttons and the light bar / 7-seg reaction display.
// PARAMETERS
// - TICK_N    default 48000  clock cycles per light tick (>=2)
// - LFSR_SEED default 7'h01  reset value of 7-bit LFSR; 0 is forced to 7'h01
// - RT_W      default 16     width of reaction-time counter
// PORTS
// - clk        in   1     clock
// - rst        in   1     synchronous, active-high reset
// - en         in   1     global enable; 0 freezes all counters, LFSR and FSM
// - trigger    in   1     start request; rising edge accepted in IDLE only
// - resp       in   1     driver reaction button, level-sampled
// - data_out   out  8     light bar, thermometer code
// - cmd_seq    out  1     1 while state==SEQ
// - cmd_delay  out  1     1 while state==HOLD
// - go         out  1     one-cycle pulse, first cycle lights read 0 after HOLD
// - rt_valid   out  1     one-cycle pulse, rt_cycles updated
// - rt_cycles  out  RT_W  reaction time in clk cycles, held until next rt_valid
// - jump_start out  1     sticky; set on early resp, cleared on next accepted trigger
// BEHAVIOUR
// - Sync reset (any state, mid-run included): state=IDLE; data_out=0; cmd_seq=cmd_delay=go=rt_valid=0;
//   rt_cycles=0; jump_start=0; trig_q=0; tick_cnt=0; lfsr=LFSR_SEED.
// - en=0: registers hold value (state, tick_cnt, delay_cnt, rt counter, lfsr, trig_q); pulses forced 0.
// - Edge detect: edge = trigger & ~trig_q; trig_q <= trigger every en cycle.
// - LFSR: x^7+x^6+1, lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}; advances on every en cycle in IDLE only
//   (including edge cycle); frozen otherwise. Never 0.
// - tick = en & (tick_cnt==TICK_N-1); tick_cnt wraps to 0 on tick; cleared on entering SEQ.
// - FSM states IDLE, SEQ, HOLD, REACT:
// - IDLE: data_out=0. edge -> SEQ next cycle, data_out=0, jump_start<=0. Edges outside IDLE ignored.
// - SEQ: each tick data_out <= {data_out[6:0],1'b1}. Tick with data_out==8'hFF -> HOLD,
//   delay_cnt <= lfsr (1..127). Lights stay full for a whole tick before HOLD.
// - HOLD: data_out=8'hFF; each tick delay_cnt--. Tick with delay_cnt==1 -> REACT, data_out<=0,
//   go=1 that cycle, rt counter<=0.
// - REACT: rt counter +1 per en cycle, saturating at 2^RT_W-1. resp=1 -> rt_cycles<=counter, rt_valid=1,
//   -> IDLE. Counter saturated with no resp -> rt_cycles=all-ones, rt_valid=1, -> IDLE (timeout).
// - resp=1 in SEQ or HOLD: jump_start<=1, data_out<=0, -> IDLE; no go, no rt_valid.
// - resp in IDLE ignored. resp and lights-out tick in same HOLD cycle: jump-start wins.
// - All outputs registered; 1-cycle latency from decision cycle.
// - Latency from accepted edge (cycle 0): SEQ at 1; k-th light at 1+k*TICK_N; HOLD at 1+9*TICK_N;
//   go at 1+(9+D)*TICK_N, D=lfsr at edge.
// TESTING (TICK_N=4, LFSR_SEED=1, RT_W=8, en=1 unless stated)
// - Rst, trigger=1 in 1st post-reset cycle (c0), LFSR 1->2 so D=2 -> data_out=01 at c5, FF at c33;
//   cmd_seq=1 c1..c36; cmd_delay=1 c37..c44; go=1, data_out=0 at c45.
// - Same run, resp high 10th REACT cycle (c54) -> rt_valid=1 at c55, rt_cycles=9, state IDLE.
// - resp=1 at c20 (SEQ) -> data_out=0, jump_start=1 at c21, go never pulses; retrigger -> jump_start=0.
// - REACT without resp -> rt_valid after 255 REACT cycles, rt_cycles=8'hFF; 2nd edge during SEQ ignored.
// - en low for 10 cycles mid-SEQ -> every later event shifted by exactly 10 cycles, data_out unchanged.
// - rst asserted mid-HOLD -> next cycle all outputs 0, IDLE, lfsr=01; trigger held high = no new edge.

Source files
------------

// File: rtl/f1_start_ctrl_if.sv
// Board-facing signal bundle of the F1 start controller: buttons and enable in,
// light bar, status strobes and reaction-time display out.
interface f1_start_ctrl_if #(
   parameter int RT_W = 16
);
   logic            en;
   logic            trigger;
   logic            resp;
   logic [7:0]      data_out;
   logic            cmd_seq;
   logic            cmd_delay;
   logic            go;
   logic            rt_valid;
   logic [RT_W-1:0] rt_cycles;
   logic            jump_start;

   modport master (
      output en, trigger, resp,
      input  data_out, cmd_seq, cmd_delay, go, rt_valid, rt_cycles, jump_start
   );

   modport slave (
      input  en, trigger, resp,
      output data_out, cmd_seq, cmd_delay, go, rt_valid, rt_cycles, jump_start
   );
endinterface

// File: rtl/f1_start_ctrl.sv
// F1 start gantry sequencer: lights fill one per tick, random hold from a 7-bit LFSR,
// lights out, then reaction-time measurement with jump-start detection.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | lights off, LFSR free-running, waiting for a trigger rising edge
// S_SEQ   | one more light per tick; a full bar is held for one extra tick
// S_HOLD  | full bar, delay_cnt ticks down from the LFSR draw
// S_REACT | lights out, counting cycles until resp or counter saturation
module f1_start_ctrl #(
   parameter int         TICK_N    = 48000,
   parameter logic [6:0] LFSR_SEED = 7'h01,
   parameter int         RT_W      = 16
) (
   input logic            clk,
   input logic            rst,
   f1_start_ctrl_if.slave bus
);
   localparam int              TW        = (TICK_N > 1) ? $clog2(TICK_N) : 1;
   localparam logic [6:0]      SEED      = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_N - 1);
   localparam logic [RT_W-1:0] RT_MAX    = '1;

   typedef enum logic [1:0] {S_IDLE, S_SEQ, S_HOLD, S_REACT} state_t;

   state_t          state_q, state_d;
   logic            trig_q, trig_d;
   logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
   logic [6:0]      delay_cnt_q, delay_cnt_d;
   logic [RT_W-1:0] rt_cnt_q, rt_cnt_d;
   logic [6:0]      lfsr_q, lfsr_d;
   logic [7:0]      data_out_q, data_out_d;
   logic            cmd_seq_q, cmd_seq_d;
   logic            cmd_delay_q, cmd_delay_d;
   logic            go_q, go_d;
   logic            rt_valid_q, rt_valid_d;
   logic [RT_W-1:0] rt_cycles_q, rt_cycles_d;
   logic            jump_start_q, jump_start_d;

   logic tick_w;
   logic trig_edge;
   logic early_resp;

   assign tick_w     = bus.en & (tick_cnt_q == TICK_LAST);
   assign trig_edge  = bus.trigger & ~trig_q;
   assign early_resp = bus.en & bus.resp & ((state_q == S_SEQ) | (state_q == S_HOLD));

   always_comb begin
      state_d      = state_q;
      trig_d       = trig_q;
      tick_cnt_d   = tick_cnt_q;
      delay_cnt_d  = delay_cnt_q;
      rt_cnt_d     = rt_cnt_q;
      lfsr_d       = lfsr_q;
      data_out_d   = data_out_q;
      cmd_seq_d    = cmd_seq_q;
      cmd_delay_d  = cmd_delay_q;
      go_d         = 1'b0;
      rt_valid_d   = 1'b0;
      rt_cycles_d  = rt_cycles_q;
      jump_start_d = jump_start_q;

      if (bus.en) begin
         trig_d     = bus.trigger;
         tick_cnt_d = tick_w ? '0 : tick_cnt_q + TW'(1);
         unique case (state_q)
            S_IDLE: begin
               lfsr_d     = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
               data_out_d = '0;
               if (trig_edge) begin
                  state_d      = S_SEQ;
                  tick_cnt_d   = '0;
                  cmd_seq_d    = 1'b1;
                  jump_start_d = 1'b0;
               end
            end
            S_SEQ: begin
               if (!bus.resp && tick_w) begin
                  if (data_out_q == 8'hFF) begin
                     state_d     = S_HOLD;
                     delay_cnt_d = lfsr_q;
                     cmd_seq_d   = 1'b0;
                     cmd_delay_d = 1'b1;
                  end else begin
                     data_out_d = {data_out_q[6:0], 1'b1};
                  end
               end
            end
            S_HOLD: begin
               if (!bus.resp && tick_w) begin
                  if (delay_cnt_q == 7'd1) begin
                     state_d     = S_REACT;
                     data_out_d  = '0;
                     cmd_delay_d = 1'b0;
                     go_d        = 1'b1;
                     rt_cnt_d    = '0;
                  end else begin
                     delay_cnt_d = delay_cnt_q - 7'd1;
                  end
               end
            end
            S_REACT: begin
               if (bus.resp) begin
                  state_d     = S_IDLE;
                  rt_cycles_d = rt_cnt_q;
                  rt_valid_d  = 1'b1;
               end else if (rt_cnt_q == RT_MAX) begin
                  state_d     = S_IDLE;
                  rt_cycles_d = RT_MAX;
                  rt_valid_d  = 1'b1;
               end else begin
                  rt_cnt_d = rt_cnt_q + RT_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase

         // an early button press aborts the start even on the lights-out tick
         if (early_resp) begin
            state_d      = S_IDLE;
            data_out_d   = '0;
            cmd_seq_d    = 1'b0;
            cmd_delay_d  = 1'b0;
            jump_start_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         trig_q       <= 1'b0;
         tick_cnt_q   <= '0;
         delay_cnt_q  <= '0;
         rt_cnt_q     <= '0;
         lfsr_q       <= SEED;
         data_out_q   <= '0;
         cmd_seq_q    <= 1'b0;
         cmd_delay_q  <= 1'b0;
         go_q         <= 1'b0;
         rt_valid_q   <= 1'b0;
         rt_cycles_q  <= '0;
         jump_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         trig_q       <= trig_d;
         tick_cnt_q   <= tick_cnt_d;
         delay_cnt_q  <= delay_cnt_d;
         rt_cnt_q     <= rt_cnt_d;
         lfsr_q       <= lfsr_d;
         data_out_q   <= data_out_d;
         cmd_seq_q    <= cmd_seq_d;
         cmd_delay_q  <= cmd_delay_d;
         go_q         <= go_d;
         rt_valid_q   <= rt_valid_d;
         rt_cycles_q  <= rt_cycles_d;
         jump_start_q <= jump_start_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.cmd_seq    = cmd_seq_q;
   assign bus.cmd_delay  = cmd_delay_q;
   assign bus.go         = go_q;
   assign bus.rt_valid   = rt_valid_q;
   assign bus.rt_cycles  = rt_cycles_q;
   assign bus.jump_start = jump_start_q;
endmodule

// File: tb/tb_f1_start_ctrl.sv
// Bench for f1_start_ctrl: each start run predicts its timeline of output events from the
// edge cycle, the LFSR draw and the tick period; a monitor matches observed output changes.
module tb_f1_start_ctrl;
   localparam int         T    = 4;
   localparam int         RT_W = 8;
   localparam logic [6:0] SEED = 7'h01;

   localparam int K_DATA  = 0;
   localparam int K_SEQ   = 1;
   localparam int K_DELAY = 2;
   localparam int K_GO    = 3;
   localparam int K_RTV   = 4;
   localparam int K_JS    = 5;
   localparam int K_RTC   = 6;

   typedef struct {
      int cyc;
      int kind;
      int val;
   } ev_t;

   logic     clk = 1'b0;
   logic     rst = 1'b1;
   int       cyc = 0;
   int       checks = 0;
   int       errors = 0;
   ev_t      exp_q[$];
   bit [6:0] lfsr_m = SEED;
   bit       js_m = 1'b0;

   f1_start_ctrl_if #(.RT_W(RT_W)) bus ();

   f1_start_ctrl #(.TICK_N(T), .LFSR_SEED(SEED), .RT_W(RT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic observe(input int kind, input logic [31:0] val);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event kind=%0d at cycle %0d: got value %0d expected no event",
                  kind, cyc, val);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("event_cycle_k%0d", e.kind), cyc, e.cyc);
         check($sformatf("event_kind_k%0d", e.kind), kind, e.kind);
         check($sformatf("event_value_k%0d", e.kind), val, e.val);
      end
   endtask

   // keep the expected queue ordered by (cycle, kind), matching the monitor's report order
   function automatic void push_ev(input int c, input int k, input int v);
      ev_t e;
      int  i;
      e.cyc  = c;
      e.kind = k;
      e.val  = v;
      i = exp_q.size();
      while (i > 0 && (exp_q[i-1].cyc > c || (exp_q[i-1].cyc == c && exp_q[i-1].kind > k))) i--;
      exp_q.insert(i, e);
   endfunction

   // decision in enabled cycle a after the edge shows on the outputs one wall cycle later
   function automatic void ev_at(input int edge_c, input int a, input int goff, input int glen,
                                 input int lim, input int kind, input int val);
      if (a < lim) push_ev(edge_c + a + ((glen > 0 && a >= goff) ? glen : 0) + 1, kind, val);
   endfunction

   task automatic step(input bit r_v, input bit en_v, input bit trig_v, input bit resp_v,
                       input bit idle);
      @(posedge clk);
      #1;
      rst         = r_v;
      bus.en      = en_v;
      bus.trigger = trig_v;
      bus.resp    = resp_v;
      if (!r_v && en_v && idle) lfsr_m = {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_data_out"}, bus.data_out, 0);
      check({tag, "_cmd_seq"}, bus.cmd_seq, 0);
      check({tag, "_cmd_delay"}, bus.cmd_delay, 0);
      check({tag, "_go"}, bus.go, 0);
      check({tag, "_rt_valid"}, bus.rt_valid, 0);
      check({tag, "_rt_cycles"}, bus.rt_cycles, 0);
      check({tag, "_jump_start"}, bus.jump_start, 0);
   endtask

   // r: REACT cycle index of resp (-1 none); jsel: enabled cycle of early resp (-1 none,
   // -2 random in SEQ/HOLD, -3 on the lights-out tick); rst_a: enabled cycle to reset in (-1 none)
   task automatic do_run(input int pre, input int r, input int jsel, input int goff,
                         input int glen, input bit xtrig, input int rst_a);
      int d, go_a, end_a, edge_c, jw, rr, nl, lim;
      bit trig_v, resp_v;
      for (int i = 0; i < pre; i++) step(0, ($urandom_range(0, 3) != 0), 0, 0, 1);
      step(0, 1, 1, 0, 1);
      edge_c = cyc;
      d      = int'(lfsr_m);
      go_a   = (9 + d) * T;
      jw     = (jsel == -2) ? int'($urandom_range(1, go_a)) : ((jsel == -3) ? go_a : jsel);
      rr     = (r < 0 || r > 255) ? 255 : r;
      end_a  = (jw >= 0) ? jw : go_a + 1 + rr;
      if (rst_a >= 0) end_a = rst_a;
      lim = (rst_a >= 0) ? rst_a : end_a + 1;

      ev_at(edge_c, 0, goff, glen, lim, K_SEQ, 1);
      if (js_m) ev_at(edge_c, 0, goff, glen, lim, K_JS, 0);
      js_m = 1'b0;
      nl = 0;
      for (int k = 1; k <= 8; k++) begin
         if (jw < 0 || k * T < jw) begin
            ev_at(edge_c, k * T, goff, glen, lim, K_DATA, (1 << k) - 1);
            nl = k;
         end
      end
      if (jw < 0 || 9 * T < jw) begin
         ev_at(edge_c, 9 * T, goff, glen, lim, K_SEQ, 0);
         ev_at(edge_c, 9 * T, goff, glen, lim, K_DELAY, 1);
      end
      if (jw >= 0) begin
         if (nl > 0) ev_at(edge_c, jw, goff, glen, lim, K_DATA, 0);
         if (jw <= 9 * T) ev_at(edge_c, jw, goff, glen, lim, K_SEQ, 0);
         else ev_at(edge_c, jw, goff, glen, lim, K_DELAY, 0);
         ev_at(edge_c, jw, goff, glen, lim, K_JS, 1);
         js_m = 1'b1;
      end else begin
         ev_at(edge_c, go_a, goff, glen, lim, K_DATA, 0);
         ev_at(edge_c, go_a, goff, glen, lim, K_DELAY, 0);
         ev_at(edge_c, go_a, goff, glen, lim, K_GO, 1);
         ev_at(edge_c, end_a, goff, glen, lim, K_RTV, rr);
      end

      for (int a = 1; a <= end_a; a++) begin
         trig_v = (a < 3) || (xtrig && a >= 10 && a < 14);
         if (glen > 0 && a == goff)
            for (int g = 0; g < glen; g++) step(0, 0, trig_v, 0, 0);
         if (rst_a >= 0 && a == rst_a) begin
            step(1, 1, 1, 0, 0);
         end else begin
            resp_v = (jw >= 0) ? (a == jw) : (r >= 0 && r <= 255 && a == go_a + 1 + r);
            step(0, 1, trig_v, resp_v, 0);
         end
      end

      if (rst_a < 0) begin
         repeat (3) step(0, 1, 0, 0, 1);
         check("events_drained", exp_q.size(), 0);
      end else begin
         step(1, 1, 1, 0, 0);
         check_reset_outs("midrun_reset");
         check("events_before_reset", exp_q.size(), 0);
         step(1, 1, 0, 0, 0);
         check_reset_outs("reset_trigger_high");
         lfsr_m = SEED;
         js_m   = 1'b0;
      end
   endtask

   initial begin
      logic [7:0]      p_data;
      logic            p_seq, p_del, p_js;
      logic [RT_W-1:0] p_rtc;
      bit              rst_last;
      rst_last = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_last) begin
            if (bus.data_out !== p_data) observe(K_DATA, 32'(bus.data_out));
            if (bus.cmd_seq !== p_seq) observe(K_SEQ, 32'(bus.cmd_seq));
            if (bus.cmd_delay !== p_del) observe(K_DELAY, 32'(bus.cmd_delay));
            if (bus.go !== 1'b0) observe(K_GO, 32'(bus.go));
            if (bus.rt_valid !== 1'b0) observe(K_RTV, 32'(bus.rt_cycles));
            else if (bus.rt_cycles !== p_rtc) observe(K_RTC, 32'(bus.rt_cycles));
            if (bus.jump_start !== p_js) observe(K_JS, 32'(bus.jump_start));
         end
         p_data   = bus.data_out;
         p_seq    = bus.cmd_seq;
         p_del    = bus.cmd_delay;
         p_rtc    = bus.rt_cycles;
         p_js     = bus.jump_start;
         rst_last = rst;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "time limit");
   end

   initial begin
      int mode;
      bus.en      = 1'b1;
      bus.trigger = 1'b0;
      bus.resp    = 1'b0;
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      check_reset_outs("power_on_reset");
      step(1, 1, 0, 0, 0);
      lfsr_m = SEED;

      do_run(0, 9, -1, 0, 0, 0, -1);
      do_run(2, -1, 20, 0, 0, 0, -1);
      do_run(3, -1, -1, 0, 0, 1, -1);
      do_run(1, 5, -1, 14, 10, 0, -1);
      do_run(2, -1, -3, 0, 0, 0, -1);
      do_run(1, 0, -1, 0, 0, 0, -1);
      do_run(2, 3, -1, 0, 0, 0, 9 * T + 3);
      do_run(0, 17, -1, 0, 0, 0, -1);
      do_run(1, -1, 1, 0, 0, 0, -1);

      for (int i = 0; i < 10; i++) begin
         mode = int'($urandom_range(0, 2));
         if (mode == 0)
            do_run(int'($urandom_range(1, 6)), int'($urandom_range(0, 60)), -1, 0, 0, 0, -1);
         else if (mode == 1)
            do_run(int'($urandom_range(1, 6)), -1, -2, 0, 0, 1, -1);
         else
            do_run(int'($urandom_range(1, 6)), int'($urandom_range(0, 60)), -1,
                   int'($urandom_range(1, 30)), int'($urandom_range(1, 12)), 0, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
